bin_fmap_packer: RTL and testbench

//  Sink for the binarised 2x2-maxpool stream (ivalid/din, 1 bit per pooled pixel, raster order).

---
 rtl/bin_fmap_packer.sv | 218 +++++++++++++++++++++
 tb/tb_bin_fmap_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_fmap_packer.sv
// -----------------------------------------------------------------------------
// bin_fmap_packer
//   Collects the binarised 2x2-maxpool pixel stream (1 bit per pooled pixel,
//   raster order) into COLS-bit row words. Each ROWS x COLS frame goes into a
//   two-bank ping-pong buffer. Every completed frame is streamed out one row
//   at a time over valid/ready. The writer cannot be stalled: a bit that
//   arrives while its target bank still holds an unread frame is dropped, and
//   the sticky overflow flag is set.
//
//   Optional feature macro: BNN_PACK_POPCNT_EN
//     Adds the opopcnt output, which gives the number of ones in odata. The
//     count is computed when a row is written and is stored next to that row.
//
// Ports
//   clk, rst    clock (posedge), asynchronous active-high reset
//   state       layer active; while low the write side is held idle and any
//               partial row or frame is discarded
//   ivalid/din  pooled pixel stream, no backpressure
//   ovalid/oready, odata/orow/olast
//               row stream; odata bit c = column c, olast marks row ROWS-1
//   frame_done  one-cycle pulse after a frame is committed to a bank
//   overflow    sticky, set when an input bit was dropped
//   opopcnt     (BNN_PACK_POPCNT_EN only) popcount of odata
// -----------------------------------------------------------------------------
module bin_fmap_packer #(
    parameter int COLS = 12,
    parameter int ROWS = 12,
    parameter int RW   = 4,
    localparam int PCW = $clog2(COLS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            state,
    input  logic            ivalid,
    input  logic            din,
    output logic            ovalid,
    output logic [COLS-1:0] odata,
    output logic [RW-1:0]   orow,
    output logic            olast,
    input  logic            oready,
    output logic            frame_done,
    output logic            overflow
`ifdef BNN_PACK_POPCNT_EN
    ,
    output logic [PCW-1:0]  opopcnt
`endif
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

    // ---------------- state ----------------
    logic [CW-1:0]   col_ptr_q, col_ptr_d;
    logic [RW-1:0]   row_ptr_q, row_ptr_d;
    logic [COLS-1:0] row_sr_q, row_sr_d;
    logic            wr_bank_q, wr_bank_d;
    logic [1:0]      full_q, full_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;

    rd_state_e       rd_state_q, rd_state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [RW-1:0]   rd_row_q, rd_row_d;

    // Frame storage. It is deliberately not reset: a bank is only read after
    // all of its rows have been written again.
    logic [COLS-1:0] bank_mem [2][ROWS];

    logic            row_we;
    logic [COLS-1:0] row_wdata;
    logic            stream;
    logic            rd_last;
    logic            free_fire;
    logic            writable;

    // ---------------- read side control ----------------
    assign stream    = (rd_state_q == RD_STREAM);
    assign rd_last   = (rd_row_q == RW'(ROWS - 1));
    assign free_fire = stream && oready && rd_last;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_row_d   = rd_row_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = RD_STREAM;
                    rd_row_d   = '0;
                end
            end
            RD_STREAM: begin
                if (oready) begin
                    if (rd_last) begin
                        rd_state_d = RD_IDLE;
                        rd_bank_d  = ~rd_bank_q;
                    end else begin
                        rd_row_d = rd_row_q + RW'(1);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // ---------------- write side ----------------
    // A bank that the reader releases in this cycle may be written in this
    // same cycle. This keeps a continuously streaming source from losing a
    // bit at the boundary between two frames.
    assign writable = !full_q[wr_bank_q] || (free_fire && (rd_bank_q == wr_bank_q));

    always_comb begin
        col_ptr_d    = col_ptr_q;
        row_ptr_d    = row_ptr_q;
        row_sr_d     = row_sr_q;
        wr_bank_d    = wr_bank_q;
        full_d       = full_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        row_we       = 1'b0;
        row_wdata    = row_sr_q;
        row_wdata[col_ptr_q] = din;

        // The release is applied first, so that a commit to the same bank
        // in this cycle sets the bank full again.
        if (free_fire)
            full_d[rd_bank_q] = 1'b0;

        if (!state) begin
            col_ptr_d = '0;
            row_ptr_d = '0;
            row_sr_d  = '0;
        end else if (ivalid) begin
            if (writable) begin
                if (col_ptr_q == CW'(COLS - 1)) begin
                    row_we    = 1'b1;
                    col_ptr_d = '0;
                    row_sr_d  = '0;
                    if (row_ptr_q == RW'(ROWS - 1)) begin
                        row_ptr_d         = '0;
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        frame_done_d      = 1'b1;
                    end else begin
                        row_ptr_d = row_ptr_q + RW'(1);
                    end
                end else begin
                    row_sr_d  = row_wdata;
                    col_ptr_d = col_ptr_q + CW'(1);
                end
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_ptr_q    <= '0;
            row_ptr_q    <= '0;
            row_sr_q     <= '0;
            wr_bank_q    <= 1'b0;
            full_q       <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            rd_state_q   <= RD_IDLE;
            rd_bank_q    <= 1'b0;
            rd_row_q     <= '0;
        end else begin
            col_ptr_q    <= col_ptr_d;
            row_ptr_q    <= row_ptr_d;
            row_sr_q     <= row_sr_d;
            wr_bank_q    <= wr_bank_d;
            full_q       <= full_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_row_q     <= rd_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (row_we)
            bank_mem[wr_bank_q][row_ptr_q] <= row_wdata;
    end

    // ---------------- outputs ----------------
    // The outputs are decoded only from registered state and from the frozen
    // contents of a full bank. They therefore hold steady during a stall, and
    // they have no path from oready.
    assign ovalid     = stream;
    assign odata      = stream ? bank_mem[rd_bank_q][rd_row_q] : '0;
    assign orow       = stream ? rd_row_q : '0;
    assign olast      = stream && rd_last;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef BNN_PACK_POPCNT_EN
    logic [PCW-1:0] pc_mem [2][ROWS];
    logic [PCW-1:0] row_pc;

    always_comb begin
        row_pc = '0;
        for (int i = 0; i < COLS; i++)
            row_pc = row_pc + PCW'(row_wdata[i]);
    end

    always_ff @(posedge clk) begin
        if (row_we)
            pc_mem[wr_bank_q][row_ptr_q] <= row_pc;
    end

    assign opopcnt = stream ? pc_mem[rd_bank_q][rd_row_q] : '0;
`endif

endmodule

// File: tb/tb_bin_fmap_packer.sv
module tb_bin_fmap_packer;
    localparam int COLS = 12;
    localparam int ROWS = 12;
    localparam int RW   = 4;
    localparam int PCW  = 4;

    logic            clk = 1'b0;
    logic            rst, state, ivalid, din, oready;
    logic            ovalid, olast, frame_done, overflow;
    logic [COLS-1:0] odata;
    logic [RW-1:0]   orow;
`ifdef BNN_PACK_POPCNT_EN
    logic [PCW-1:0]  opopcnt;
`endif

    bin_fmap_packer #(.COLS(COLS), .ROWS(ROWS), .RW(RW)) dut (
        .clk(clk), .rst(rst), .state(state), .ivalid(ivalid), .din(din),
        .ovalid(ovalid), .odata(odata), .orow(orow), .olast(olast),
        .oready(oready), .frame_done(frame_done), .overflow(overflow)
`ifdef BNN_PACK_POPCNT_EN
        , .opopcnt(opopcnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [COLS-1:0] d;
        logic [RW-1:0]   r;
        logic            l;
        logic [PCW-1:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_count = 0;
    int   fd_count = 0;
    bit   tog = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: it pops the scoreboard on each handshake and checks
    // that the outputs stay stable during a stall.
    initial begin
        logic            prev_stall;
        logic [COLS-1:0] prev_d;
        logic [RW-1:0]   prev_r;
        exp_t            e;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_r = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (frame_done) fd_count++;
            if (prev_stall) begin
                chk("stall_ovalid", 32'(ovalid), 32'd1);
                chk("stall_odata", 32'(odata), 32'(prev_d));
                chk("stall_orow", 32'(orow), 32'(prev_r));
            end
            if (ovalid && oready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    chk("unexpected_row", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("odata", 32'(odata), 32'(e.d));
                    chk("orow", 32'(orow), 32'(e.r));
                    chk("olast", 32'(olast), 32'(e.l));
`ifdef BNN_PACK_POPCNT_EN
                    chk("opopcnt", 32'(opopcnt), 32'(e.pc));
`endif
                end
            end
            prev_stall = ovalid && !oready;
            prev_d = odata;
            prev_r = orow;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) oready = ~oready;
    endtask

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return (k % 3) == 0;
            1:       return 1'b1;
            2:       return ((k * 5) % 7) < 3;
            default: return (k & 1) != 0;
        endcase
    endfunction

    task automatic send_frame(input int mode, input bit push, input bit gaps);
        logic [COLS-1:0] row;
        exp_t            e;
        row = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                row[c] = pat(mode, r * COLS + c);
                ivalid = 1'b1;
                din = row[c];
                tick();
                if (gaps && $urandom_range(0, 2) == 0) begin
                    ivalid = 1'b0;
                    tick();
                end
            end
            if (push) begin
                e.d  = row;
                e.r  = RW'(r);
                e.l  = (r == ROWS - 1);
                e.pc = PCW'($countones(row));
                sb.push_back(e);
            end
        end
        ivalid = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic b);
        for (int i = 0; i < n; i++) begin
            ivalid = 1'b1;
            din = b;
            tick();
        end
        ivalid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || ovalid) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int hs0, fd0, n;
        rst = 1'b1; state = 1'b0; ivalid = 1'b0; din = 1'b0; oready = 1'b0;
        #3;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_orow", 32'(orow), 32'd0);
        chk("rst_olast", 32'(olast), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // T1: one frame with no backpressure
        state = 1'b1; oready = 1'b1;
        hs0 = hs_count; fd0 = fd_count;
        send_frame(0, 1'b1, 1'b0);
        drain("t1_drain", 200);
        chk("t1_handshakes", 32'(hs_count - hs0), 32'd12);
        chk("t1_frame_done", 32'(fd_count - fd0), 32'd1);

        // T2: oready toggles every cycle
        tog = 1'b1; oready = 1'b1;
        hs0 = hs_count;
        send_frame(2, 1'b1, 1'b0);
        drain("t2_drain", 300);
        tog = 1'b0; oready = 1'b1;
        chk("t2_handshakes", 32'(hs_count - hs0), 32'd12);

        // T3: both banks fill and the third frame is dropped
        oready = 1'b0;
        hs0 = hs_count; fd0 = fd_count;
        send_frame(0, 1'b1, 1'b0);
        send_frame(2, 1'b1, 1'b0);
        chk("t3_no_overflow_288", 32'(overflow), 32'd0);
        chk("t3_full", 32'(dut.full_q), 32'd3);
        send_bits(1, 1'b1);
        chk("t3_overflow_289", 32'(overflow), 32'd1);
        send_bits(143, 1'b1);
        chk("t3_full_after", 32'(dut.full_q), 32'd3);
        chk("t3_frame_done", 32'(fd_count - fd0), 32'd2);
        oready = 1'b1;
        drain("t3_drain", 400);
        chk("t3_handshakes", 32'(hs_count - hs0), 32'd24);
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // T4: abort a partial frame, then send frames with gaps
        hs0 = hs_count; fd0 = fd_count;
        send_bits(17, 1'b0);
        state = 1'b0;
        tick();
        state = 1'b1;
        send_frame(1, 1'b1, 1'b1);
        send_frame(3, 1'b1, 1'b1);
        drain("t4_drain", 600);
        chk("t4_handshakes", 32'(hs_count - hs0), 32'd24);
        chk("t4_frame_done", 32'(fd_count - fd0), 32'd2);

        // T5: assert reset in the middle of the stream at row 5
        oready = 1'b0;
        send_frame(0, 1'b1, 1'b0);
        oready = 1'b1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (ovalid && orow == RW'(5)) begin
                oready = 1'b0;
                break;
            end
        end
        chk("t5_reach_row5", 32'(n < 100), 32'd1);
        chk("t5_overflow_before", 32'(overflow), 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t5_ovalid", 32'(ovalid), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_full", 32'(dut.full_q), 32'd0);
        chk("t5_odata", 32'(odata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        oready = 1'b1;
        hs0 = hs_count;
        send_frame(2, 1'b1, 1'b0);
        n = 0;
        while (!ovalid && n < 50) begin
            tick();
            n++;
        end
        chk("t5_restart_valid", 32'(ovalid), 32'd1);
        chk("t5_restart_orow", 32'(orow), 32'd0);
        chk("t5_restart_bank", 32'(dut.rd_bank_q), 32'd0);
        drain("t5_drain", 200);
        chk("t5_handshakes", 32'(hs_count - hs0), 32'd12);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
